// File: rtl/fp_pkg.sv
// Shared constants and result layout for the FPAddSub receive path.
package fp_pkg;

    localparam int FP_W              = 32;
    localparam int FLAGS_W           = 5;
    // Must track the pipeline depth of the FPAddSub core this block sits behind.
    localparam int FPADDSUB_LATENCY  = 5;
    localparam int FP_TAG_W          = 4;

    typedef struct packed {
        logic [FP_W-1:0]     z;
        logic [FLAGS_W-1:0]  flags;
        logic [FP_TAG_W-1:0] tag;
    } fp_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: registered storage and pointers, no write-to-read bypass.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 din_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until the slot is pushed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/fp_addsub_result_capture.sv
// Tracks operations issued into the fixed-latency FPAddSub pipeline, captures
// Z/Flags on the cycle they emerge, and buffers them for a valid/ready consumer.
//
// Handshakes: an issue is taken on a clock edge where issue_valid && issue_ready;
// a result is consumed on an edge where res_valid && res_ready. res_* hold steady
// while res_valid && !res_ready. issue_ready is a credit: every outstanding op
// (in the delay line or buffered) holds one FIFO slot, so a capture never
// finds the FIFO full.
module fp_addsub_result_capture
    import fp_pkg::*;
#(
    parameter int LATENCY = FPADDSUB_LATENCY,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic [TAG_W-1:0]            issue_tag,
    output logic                        issue_ready,
    input  logic [FP_W-1:0]             Z_in,
    input  logic [FLAGS_W-1:0]          Flags_in,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [FP_W-1:0]             res_z,
    output logic [FLAGS_W-1:0]          res_flags,
    output logic [TAG_W-1:0]            res_tag,
    output logic                        res_exc,
    output logic [$clog2(DEPTH+1)-1:0]  in_flight,
    output logic                        proto_err
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int RW = FP_W + FLAGS_W + TAG_W;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [TAG_W-1:0]   tag_d [LATENCY];
    logic [CW-1:0]      in_flight_q, in_flight_d;
    logic               proto_err_q, proto_err_d;

    logic               accept;
    logic               last_vld;
    logic [CW:0]        used;

    logic               fifo_push, fifo_pop;
    logic [RW-1:0]      fifo_din, fifo_dout;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty;

    // Credit is computed from registered counts only, so a pop this cycle frees
    // its slot for issue starting next cycle.
    assign used        = {1'b0, in_flight_q} + {1'b0, fifo_count};
    assign issue_ready = (used < (CW+1)'(DEPTH));
    assign accept      = issue_valid && issue_ready;
    assign last_vld    = vld_q[LATENCY-1];

    // Delay line mirrors the FPAddSub pipeline: it never stalls.
    always_comb begin
        vld_d[0] = accept;
        tag_d[0] = issue_tag;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
        in_flight_d = in_flight_q + CW'(accept) - CW'(last_vld);
        proto_err_d = proto_err_q | (issue_valid & ~issue_ready);
    end

    // Delay-line, occupancy and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            in_flight_q <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            vld_q       <= vld_d;
            in_flight_q <= in_flight_d;
            proto_err_q <= proto_err_d;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= tag_d[i];
        end
    end

    // Z_in/Flags_in are only meaningful when the last stage is valid.
    assign fifo_din  = {Z_in, Flags_in, tag_q[LATENCY-1]};
    assign fifo_pop  = res_valid && res_ready;
    assign fifo_push = last_vld && (!fifo_full || fifo_pop);

    sync_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head fields are forced to zero when nothing is buffered.
    assign res_valid = !fifo_empty;
    assign res_z     = res_valid ? fifo_dout[RW-1 -: FP_W]      : '0;
    assign res_flags = res_valid ? fifo_dout[TAG_W +: FLAGS_W]  : '0;
    assign res_tag   = res_valid ? fifo_dout[TAG_W-1:0]         : '0;
    assign res_exc   = |res_flags;
    assign in_flight = in_flight_q;
    assign proto_err = proto_err_q;

endmodule

// File: doc/fp_addsub_result_capture.md
Name: fp_addsub_result_capture

Overview:
- Receive-side companion to FPAddSub: it tracks each operation issued into the fixed-latency FPAddSub pipeline.
- It captures Z/Flags in the cycle they emerge, tags each one, and buffers it in a small FIFO.
- Results are presented downstream on a valid/ready interface.
- Credit-based issue_ready prevents an issued result from ever finding the FIFO full.

Parameters:
- LATENCY, 5, cycles from the FPAddSub operand-sampling edge to Z/Flags valid; must be >=1.
- DEPTH, 4, result FIFO entries; power of two, >=2.
- TAG_W, 4, width of the per-operation tag carried alongside the result.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- issue_valid  in  1  operands A/B/Ctrl are presented to FPAddSub this cycle
- issue_tag  in  TAG_W  tag travelling with this operation
- issue_ready  out  1  credit available; issue accepted only when issue_valid&&issue_ready
- Z_in  in  32  FPAddSub Z output
- Flags_in  in  5  FPAddSub Flags output
- res_valid  out  1  FIFO head valid
- res_ready  in  1  downstream accepts head
- res_z  out  32  head result
- res_flags  out  5  head flags, passed through unmodified
- res_tag  out  TAG_W  head tag
- res_exc  out  1  OR of res_flags
- in_flight  out  $clog2(DEPTH+1)  number of valid stages in the delay line
- proto_err  out  1  sticky: issue_valid seen while issue_ready=0

Behaviour:
- Reset: one clock, synchronous, active-high (rst); all state cleared.
  - Delay-line valids=0, FIFO empty, in_flight=0, proto_err=0.
  - res_valid=0; res_z/res_flags/res_tag=0.
  - issue_ready=1 in the first cycle after reset.
  - Reset mid-operation drops all in-flight and buffered results; Z_in arriving afterwards is ignored because its stage valid is 0.
- Delay line: LATENCY-stage shift register of {valid, tag}, advancing every cycle unconditionally (FPAddSub has no stall).
  - Stage 0 loads {issue_valid&&issue_ready, issue_tag}.
- Capture: when the last stage is valid in cycle t, the module samples Z_in/Flags_in.
  - That cycle is the LATENCY-th edge after the issue edge.
  - The sample is written into the FIFO with the tag at that edge.
  - res_valid is asserted from the next cycle. Total issue-edge to res_valid = LATENCY+1 cycles when the FIFO was empty.
- FIFO: registered, no bypass.
  - Pop on res_valid&&res_ready.
  - Push and pop in the same cycle: both happen and occupancy is unchanged.
  - res_* are stable while res_valid&&!res_ready.
- Credit: issue_ready = (in_flight + fifo_count) < DEPTH, combinational from registered counts.
  - A pop in the current cycle does not raise issue_ready until the next cycle.
  - Consequence: a push never finds the FIFO full.
- Protocol violation: issue_valid&&!issue_ready.
  - The operation is not tracked and proto_err is set.
  - proto_err is cleared only by rst.
- in_flight and fifo_count each saturate conceptually at DEPTH. Wrap-around of FIFO pointers is modulo DEPTH.
- Ordering: results leave in issue order; tags are not used for reordering.
- Z_in/Flags_in are ignored in every cycle where the last stage is not valid.

Decomposition:
- Shared package fp_pkg holds:
  - FP_W=32, FLAGS_W=5.
  - FPADDSUB_LATENCY, the default for LATENCY, kept consistent with the FPAddSub pipeline.
  - A typedef fp_result_t {z, flags, tag}.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop, count, full/empty), instantiated with width FP_W+FLAGS_W+TAG_W.

Test Plan:
- After reset: res_valid=0, issue_ready=1, in_flight=0, proto_err=0. Then issue tag 3 at edge 0, with a stub driving Z_in=0x40000000 (1+1) and Flags_in=0 in cycle 5 -> res_valid at cycle 6, res_z=0x40000000, res_tag=3, res_exc=0.
- Back-to-back issue of tags 0..3 with res_ready=0, stub Z = 0x40800000, 0x40C00000, 0x40A80000, 0x41E13333:
  - issue_ready=0 after the 4th issue.
  - Then res_ready=1 drains the four results in order with correct tags.
  - issue_ready returns to 1 the cycle after the first pop.
- Stub Flags_in=5'b00100 with Z=0x00000000 (1-1) -> res_flags=5'b00100, res_exc=1.
- Hold issue_valid=1 with issue_ready=0 -> proto_err=1 and stays 1; the rejected op produces no result even though the stub drives Z_in.
- Issue 3 ops, assert rst at cycle 3 for one cycle -> no res_valid ever appears for those ops; in_flight=0 after reset.
- Continuous issue with res_ready=1 every cycle:
  - Steady state issue_ready=1 with throughput 1/cycle when DEPTH>=LATENCY+2; with the default DEPTH=4 it throttles.
  - Check no loss or duplication over 20 ops by tag sequence.
